// File: rtl/if_id_stage.sv
// IF stage + IF/ID register: 1-cycle imem_addr -> if_id_instr; stall holds PC/IF/ID, redirect/flush bubble IF/ID.
// Optional IF_PERF_CNT_EN adds fetch_cnt/bubble_cnt performance counters.
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  op_code
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifIdT;

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] nextPc;
  logic        redirect;
  logic        clearIfId;
  ifIdT        ifId;
  ifIdT        ifIdNext;

  assign pc4       = pc + 32'd4;
  assign redirect  = branch_taken | jump;
  assign clearIfId = redirect | flush;

  // Redirect wins over stall: the stalled wrong-path word is dropped anyway.
  always_comb begin
    nextPc = pc4;
    if (branch_taken)
      nextPc = branch_target & 32'hFFFF_FFFC;
    else if (jump)
      nextPc = {ifId.pc4[31:28], jump_index, 2'b00};
    else if (stall)
      nextPc = pc;
  end

  always_comb begin
    ifIdNext = '{instr: imem_rdata, pc4: pc4, valid: 1'b1};
    if (clearIfId)
      ifIdNext = '0;
    else if (stall)
      ifIdNext = ifId;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= PC_RESET;
      ifId <= '0;
    end else begin
      pc   <= nextPc;
      ifId <= ifIdNext;
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = ifId.instr;
  assign if_id_pc4   = ifId.pc4;
  assign if_id_valid = ifId.valid;
  assign op_code     = ifId.instr[31:26];

`ifdef IF_PERF_CNT_EN
  // A stalled edge and a cleared edge each count as one lost issue slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (!clearIfId && !stall)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (clearIfId || stall)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reference model plus literal checkpoints, two PC_RESET configurations.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, jump, branch_taken;
  logic [25:0] jump_index;
  logic [31:0] branch_target;

  logic [31:0] addr0, rdata0, instr0, pc40;
  logic        valid0;
  logic [5:0]  op0;
  logic [31:0] addr1, rdata1, instr1, pc41;
  logic        valid1;
  logic [5:0]  op1;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fcnt0, bcnt0, fcnt1, bcnt1;
`endif

  int tests = 0;
  int fails = 0;
  bit chkEn = 1'b0;

  always #5 clk = ~clk;

  assign rdata0 = addr0 ^ 32'hA5A5_0000;
  assign rdata1 = addr1 ^ 32'hA5A5_0000;

  if_id_stage dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .jump(jump),
    .jump_index(jump_index), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(addr0), .imem_rdata(rdata0), .if_id_instr(instr0), .if_id_pc4(pc40),
    .if_id_valid(valid0), .op_code(op0)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fcnt0), .bubble_cnt(bcnt0)
`endif
  );

  if_id_stage #(.PC_RESET(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .jump(jump),
    .jump_index(jump_index), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(addr1), .imem_rdata(rdata1), .if_id_instr(instr1), .if_id_pc4(pc41),
    .if_id_valid(valid1), .op_code(op1)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fcnt1), .bubble_cnt(bcnt1)
`endif
  );

  // Reference model: architectural view of one fetch unit.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fetches;
    logic [31:0] bubbles;
  } modelT;

  modelT m0, m1;

  function automatic modelT modelReset(logic [31:0] rv);
    modelT r;
    r.pc = rv; r.instr = 0; r.pc4 = 0; r.valid = 0; r.fetches = 0; r.bubbles = 0;
    return r;
  endfunction

  function automatic modelT modelStep(modelT s);
    modelT r = s;
    logic [31:0] seqPc = s.pc + 32'd4;
    if (branch_taken)      r.pc = {branch_target[31:2], 2'b00};
    else if (jump)         r.pc = {s.pc4[31:28], jump_index, 2'b00};
    else if (!stall)       r.pc = seqPc;
    if (branch_taken || jump || flush) begin
      r.instr = 0; r.pc4 = 0; r.valid = 0; r.bubbles = s.bubbles + 1;
    end else if (stall) begin
      r.bubbles = s.bubbles + 1;
    end else begin
      r.instr = s.pc ^ 32'hA5A5_0000; r.pc4 = seqPc; r.valid = 1; r.fetches = s.fetches + 1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= modelReset(32'h0000_0000);
      m1 <= modelReset(32'hFFFF_FFF8);
    end else begin
      m0 <= modelStep(m0);
      m1 <= modelStep(m1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      check("m0.addr", addr0, m0.pc);
      check("m0.instr", instr0, m0.instr);
      check("m0.pc4", pc40, m0.pc4);
      check("m0.valid", {31'b0, valid0}, {31'b0, m0.valid});
      check("m0.op", {26'b0, op0}, {26'b0, m0.instr[31:26]});
      check("m1.addr", addr1, m1.pc);
      check("m1.pc4", pc41, m1.pc4);
      check("m1.valid", {31'b0, valid1}, {31'b0, m1.valid});
`ifdef IF_PERF_CNT_EN
      check("m0.fcnt", fcnt0, m0.fetches);
      check("m0.bcnt", bcnt0, m0.bubbles);
      check("m1.fcnt", fcnt1, m1.fetches);
      check("m1.bcnt", bcnt1, m1.bubbles);
`endif
    end
  end

  // Apply one cycle of controls, let an edge pass, return just after the falling edge.
  task automatic step(input logic bt, input logic [31:0] tgt, input logic j,
                      input logic [25:0] ji, input logic st, input logic fl);
    branch_taken = bt; branch_target = tgt; jump = j; jump_index = ji; stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0; jump = 0; branch_taken = 0;
    jump_index = 0; branch_target = 0;
    @(negedge clk); @(negedge clk); #1;
    check("rst.addr0", addr0, 32'h0);
    check("rst.instr0", instr0, 32'h0);
    check("rst.pc40", pc40, 32'h0);
    check("rst.valid0", {31'b0, valid0}, 32'h0);
    check("rst.op0", {26'b0, op0}, 32'h0);
    check("rst.addr1", addr1, 32'hFFFF_FFF8);
    rst = 1'b0;
    chkEn = 1'b1;

    plain(1);
    check("t1.addr", addr0, 32'h4);
    check("t1.instr", instr0, 32'hA5A5_0000);
    check("t1.pc4", pc40, 32'h4);
    check("t1.valid", {31'b0, valid0}, 32'h1);
    check("t1.op", {26'b0, op0}, 32'h29);
    check("t5.addr1a", addr1, 32'hFFFF_FFFC);
    plain(1);
    check("t1.addr8", addr0, 32'h8);
    check("t5.addr1wrap", addr1, 32'h0);
    check("t5.pc4wrap", pc41, 32'h0);

    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("t2.addrHold", addr0, 32'h8);
    check("t2.instrHold", instr0, 32'hA5A5_0004);
    check("t2.pc4Hold", pc40, 32'h8);
    plain(1);
    check("t2.resumeInstr", instr0, 32'hA5A5_0008);
    check("t2.resumeAddr", addr0, 32'hC);

    plain(2);
    step(0, 0, 0, 0, 0, 1);
    check("t6.flushValid", {31'b0, valid0}, 32'h0);
    plain(5);
`ifdef IF_PERF_CNT_EN
    check("t6.fetchCnt", fcnt0, 32'd10);
    check("t6.bubbleCnt", bcnt0, 32'd3);
`endif

    step(1, 32'h1000_000C, 0, 0, 0, 0);
    check("t3.brValid", {31'b0, valid0}, 32'h0);
    plain(1);
    check("t3.pc4", pc40, 32'h1000_0010);
    check("t3.instr", instr0, 32'hB5A5_000C);
    step(0, 0, 1, 26'h40, 0, 0);
    check("t3.jumpPc", addr0, 32'h1000_0100);
    check("t3.jumpValid", {31'b0, valid0}, 32'h0);

    step(1, 32'h200, 1, 26'h40, 0, 0);
    check("t4.brOverJump", addr0, 32'h200);
    step(1, 32'h303, 0, 0, 1, 0);
    check("t4.brOverStall", addr0, 32'h300);
    check("t4.brStallValid", {31'b0, valid0}, 32'h0);
    plain(1);
    step(0, 0, 0, 0, 1, 1);
    check("t4.stallFlushPc", addr0, 32'h304);
    check("t4.stallFlushValid", {31'b0, valid0}, 32'h0);
    step(0, 0, 1, 26'h10, 1, 0);
    check("t4.jumpOverStall", addr0, 32'h40);
    plain(3);

    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5.asyncAddr0", addr0, 32'h0);
    check("t5.asyncValid0", {31'b0, valid0}, 32'h0);
    check("t5.asyncAddr1", addr1, 32'hFFFF_FFF8);
    check("t5.asyncInstr0", instr0, 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    plain(3);
    check("t5.afterRst", addr0, 32'hC);

    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
